// File: rtl/x_feeder.sv
// Host-to-core input stage: buffers host bytes in a small FIFO, pulses start_in once per
// frame, streams exactly FRAME_LEN bytes on X_load/valid_input, then waits for core_finish.
module x_feeder #(
    parameter int DATA_W     = 8,
    parameter int FRAME_LEN  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LOAD_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              frame_go,
    input  logic              core_finish,
    output logic              start_in,
    output logic              valid_input,
    output logic [DATA_W-1:0] X_load,
    output logic              busy,
    output logic [7:0]        frames_done
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(FRAME_LEN + 1);
    localparam int DLW = (LOAD_DELAY < 2) ? 1 : $clog2(LOAD_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_STREAM  = 3'd3,
        S_FINWAIT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [DLW-1:0]      dly_q, dly_d;
    logic [7:0]          frames_done_q, frames_done_d;
    logic                host_ready_q, host_ready_d;
    logic                start_in_q, start_in_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   x_load_q, x_load_d;
    logic                busy_q, busy_d;
    logic                push_s, pop_s;

    // FIFO bookkeeping, frame FSM and next values of all registered outputs
    always_comb begin
        push_s        = host_valid && host_ready_q;
        pop_s         = (state_q == S_STREAM) && (count_q != '0);
        mem_d         = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = host_data;
        end else begin
            mem_d = mem_q;
        end
        wr_ptr_d      = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q + CW'(push_s) - CW'(pop_s);
        // host_ready follows the occupancy only, so a simultaneous pop never frees a slot early
        host_ready_d  = (count_d != CW'(FIFO_DEPTH));

        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        dly_d         = dly_q;
        frames_done_d = frames_done_q;
        case (state_q)
            S_IDLE: begin
                if (frame_go) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                dly_d = DLW'(LOAD_DELAY);
                if (LOAD_DELAY == 0) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dly_q <= DLW'(1)) begin
                    state_d = S_STREAM;
                end else begin
                    dly_d = dly_q - DLW'(1);
                end
            end
            S_STREAM: begin
                if (pop_s) begin
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (byte_cnt_q == BCW'(FRAME_LEN - 1)) begin
                        state_d = S_FINWAIT;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_FINWAIT: begin
                if (core_finish) begin
                    state_d       = S_IDLE;
                    byte_cnt_d    = '0;
                    frames_done_d = frames_done_q + 8'd1;
                end else begin
                    state_d = S_FINWAIT;
                end
            end
            default: begin
                state_d    = S_IDLE;
                byte_cnt_d = '0;
            end
        endcase

        valid_d    = pop_s;
        x_load_d   = pop_s ? mem_q[rd_ptr_q] : x_load_q;
        start_in_d = (state_d == S_START);
        busy_d     = (state_d != S_IDLE);
    end

    // State, FIFO and output registers; reset aborts any frame in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            byte_cnt_q    <= '0;
            dly_q         <= '0;
            frames_done_q <= 8'd0;
            host_ready_q  <= 1'b0;
            start_in_q    <= 1'b0;
            valid_q       <= 1'b0;
            x_load_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            byte_cnt_q    <= byte_cnt_d;
            dly_q         <= dly_d;
            frames_done_q <= frames_done_d;
            host_ready_q  <= host_ready_d;
            start_in_q    <= start_in_d;
            valid_q       <= valid_d;
            x_load_q      <= x_load_d;
            busy_q        <= busy_d;
        end
    end

    assign host_ready  = host_ready_q;
    assign start_in    = start_in_q;
    assign valid_input = valid_q;
    assign X_load      = x_load_q;
    assign busy        = busy_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_x_feeder.sv
// Directed bench for x_feeder with FRAME_LEN=4, FIFO_DEPTH=4, LOAD_DELAY=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_x_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_valid;
    logic [7:0] host_data;
    logic       host_ready;
    logic       frame_go;
    logic       core_finish;
    logic       start_in;
    logic       valid_input;
    logic [7:0] X_load;
    logic       busy;
    logic [7:0] frames_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] fill_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] star_b [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic [7:0] bb_b   [8] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};

    x_feeder #(
        .DATA_W(8), .FRAME_LEN(4), .FIFO_DEPTH(4), .LOAD_DELAY(2)
    ) dut (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_data(host_data),
        .host_ready(host_ready), .frame_go(frame_go), .core_finish(core_finish),
        .start_in(start_in), .valid_input(valid_input), .X_load(X_load),
        .busy(busy), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    // Stimulus only: push four consecutive byte values into an empty FIFO
    task automatic push4(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1;
            host_data  = base + 8'(i);
            @(negedge clk);
        end
        host_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; host_valid = 1'b0; host_data = 8'h00; frame_go = 1'b0; core_finish = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({start_in, valid_input, busy, X_load, frames_done} !== 19'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0", {start_in, valid_input, busy, X_load, frames_done});
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (host_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_host_ready: got %b required 1", host_ready);
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (host_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL fill_ready[%0d]: got %b required 1", i, host_ready);
            end
            host_valid = 1'b1;
            host_data  = fill_b[i];
            @(negedge clk);
            tests_run++;
            if ({start_in, valid_input} !== 2'b00) begin
                tests_failed++;
                $display("FAIL fill_quiet[%0d]: got %b required 00", i, {start_in, valid_input});
            end
        end
        tests_run++;
        if (host_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: got %b required 0", host_ready);
        end
        host_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame;
        logic exp_v;
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        tests_run++;
        if ({start_in, busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL frame_start: got %b required 11", {start_in, busy});
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_v = (k >= 4) && (k <= 7);
            tests_run++;
            if ({valid_input, start_in, busy} !== {exp_v, 1'b0, 1'b1}) begin
                tests_failed++;
                $display("FAIL frame_ctl[k=%0d]: got %b required %b", k, {valid_input, start_in, busy}, {exp_v, 2'b01});
            end
            if (k >= 4) begin
                tests_run++;
                if (X_load !== fill_b[(k > 7) ? 3 : k - 4]) begin
                    tests_failed++;
                    $display("FAIL frame_data[k=%0d]: got %h required %h", k, X_load, fill_b[(k > 7) ? 3 : k - 4]);
                end
            end
        end
        tests_run++;
        if (frames_done !== 8'd0) begin
            tests_failed++;
            $display("FAIL frame_done_before: got %0d required 0", frames_done);
        end
        core_finish = 1'b1;
        @(negedge clk);
        core_finish = 1'b0;
        tests_run++;
        if ({busy, frames_done} !== {1'b0, 8'd1}) begin
            tests_failed++;
            $display("FAIL frame_done_after: got busy=%b done=%0d required busy=0 done=1", busy, frames_done);
        end
    endtask

    task automatic test_starved;
        int beats = 0;
        int pushed = 0;
        logic prev_v = 1'b0;
        logic [7:0] prev_x;
        prev_x = X_load;
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            host_valid = 1'b0;
            if (valid_input === 1'b1) begin
                tests_run++;
                if (prev_v !== 1'b0 || beats >= 4 || X_load !== star_b[(beats > 3) ? 3 : beats]) begin
                    tests_failed++;
                    $display("FAIL starved_beat[k=%0d]: got prev_v=%b beat=%0d data=%h required isolated beat data=%h",
                             k, prev_v, beats, X_load, star_b[(beats > 3) ? 3 : beats]);
                end
                beats++;
            end else begin
                tests_run++;
                if (X_load !== prev_x) begin
                    tests_failed++;
                    $display("FAIL starved_hold[k=%0d]: got %h required %h", k, X_load, prev_x);
                end
            end
            prev_v = valid_input;
            prev_x = X_load;
            if (k >= 4 && (k - 4) % 3 == 0 && pushed < 4) begin
                host_valid = 1'b1;
                host_data  = star_b[pushed];
                pushed++;
            end
        end
        tests_run++;
        if (beats !== 4 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL starved_count: got beats=%0d busy=%b required beats=4 busy=1", beats, busy);
        end
        core_finish = 1'b1;
        @(negedge clk);
        core_finish = 1'b0;
        tests_run++;
        if (frames_done !== 8'd2) begin
            tests_failed++;
            $display("FAIL starved_done: got %0d required 2", frames_done);
        end
    endtask

    task automatic test_back_to_back;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fork
            begin : feeder
                int idx = 0;
                logic prev_ok = 1'b0;
                host_valid = 1'b1;
                host_data  = bb_b[0];
                prev_ok    = host_ready;
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (host_valid && prev_ok) idx++;
                    prev_ok = host_ready;
                    if (idx < 8) begin
                        host_valid = 1'b1;
                        host_data  = bb_b[idx];
                    end else begin
                        host_valid = 1'b0;
                        break;
                    end
                end
            end
            begin : control
                for (int f = 0; f < 2; f++) begin
                    int beats = 0;
                    frame_go = 1'b1;
                    @(negedge clk);
                    frame_go = 1'b0;
                    for (int c = 0; c < 60 && beats < 4; c++) begin
                        @(negedge clk);
                        if (valid_input === 1'b1) begin
                            tests_run++;
                            if (X_load !== bb_b[f * 4 + beats]) begin
                                tests_failed++;
                                $display("FAIL b2b_data[f%0d b%0d]: got %h required %h", f, beats, X_load, bb_b[f * 4 + beats]);
                            end
                            beats++;
                        end
                    end
                    tests_run++;
                    if (beats !== 4) begin
                        tests_failed++;
                        $display("FAIL b2b_beats[f%0d]: got %0d required 4", f, beats);
                    end
                    for (int c = 0; c < 2; c++) begin
                        @(negedge clk);
                        tests_run++;
                        if ({valid_input, busy} !== 2'b01) begin
                            tests_failed++;
                            $display("FAIL b2b_finwait[f%0d]: got %b required 01", f, {valid_input, busy});
                        end
                    end
                    core_finish = 1'b1;
                    @(negedge clk);
                    core_finish = 1'b0;
                end
            end
        join
        tests_run++;
        if ({busy, frames_done} !== {1'b0, 8'd2}) begin
            tests_failed++;
            $display("FAIL b2b_done: got busy=%b done=%0d required busy=0 done=2", busy, frames_done);
        end
    endtask

    task automatic test_reset_mid;
        int beats = 0;
        push4(8'h61);
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        for (int c = 0; c < 40 && beats < 2; c++) begin
            @(negedge clk);
            if (valid_input === 1'b1) beats++;
        end
        tests_run++;
        if (beats !== 2 || X_load !== 8'h62) begin
            tests_failed++;
            $display("FAIL midrst_pre: got beats=%0d data=%h required beats=2 data=62", beats, X_load);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({start_in, valid_input, busy, X_load, frames_done} !== 19'd0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %h required 0", {start_in, valid_input, busy, X_load, frames_done});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({host_ready, busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL midrst_release: got %b required 10", {host_ready, busy});
        end
        push4(8'h71);
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        beats = 0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            @(negedge clk);
            if (valid_input === 1'b1) begin
                tests_run++;
                if (X_load !== 8'h71 + 8'(beats)) begin
                    tests_failed++;
                    $display("FAIL midrst_new[%0d]: got %h required %h", beats, X_load, 8'h71 + 8'(beats));
                end
                beats++;
            end
        end
        @(negedge clk);
        core_finish = 1'b1;
        @(negedge clk);
        core_finish = 1'b0;
        tests_run++;
        if ({beats, frames_done} !== {32'd4, 8'd1}) begin
            tests_failed++;
            $display("FAIL midrst_done: got beats=%0d done=%0d required beats=4 done=1", beats, frames_done);
        end
    endtask

    task automatic test_spurious;
        int beats = 0;
        core_finish = 1'b1;
        @(negedge clk);
        core_finish = 1'b0;
        tests_run++;
        if ({busy, frames_done} !== {1'b0, 8'd1}) begin
            tests_failed++;
            $display("FAIL spur_idle: got busy=%b done=%0d required busy=0 done=1", busy, frames_done);
        end
        push4(8'h81);
        frame_go = 1'b1;
        @(negedge clk);
        frame_go = 1'b0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            @(negedge clk);
            core_finish = 1'b0;
            frame_go    = 1'b0;
            tests_run++;
            if (start_in !== 1'b0 || frames_done !== 8'd1) begin
                tests_failed++;
                $display("FAIL spur_stream[c=%0d]: got start=%b done=%0d required start=0 done=1", c, start_in, frames_done);
            end
            if (valid_input === 1'b1) begin
                tests_run++;
                if (X_load !== 8'h81 + 8'(beats)) begin
                    tests_failed++;
                    $display("FAIL spur_data[%0d]: got %h required %h", beats, X_load, 8'h81 + 8'(beats));
                end
                if (beats == 0) begin
                    core_finish = 1'b1;
                    frame_go    = 1'b1;
                end
                beats++;
            end
        end
        @(negedge clk);
        tests_run++;
        if ({beats, busy, valid_input, start_in} !== {32'd4, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL spur_finwait: got beats=%0d busy=%b v=%b s=%b required 4 1 0 0", beats, busy, valid_input, start_in);
        end
        core_finish = 1'b1;
        @(negedge clk);
        core_finish = 1'b0;
        tests_run++;
        if ({busy, frames_done} !== {1'b0, 8'd2}) begin
            tests_failed++;
            $display("FAIL spur_done: got busy=%b done=%0d required busy=0 done=2", busy, frames_done);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_frame();
        test_starved();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/x_feeder.md
Name: x_feeder

Overview:
- Upstream input stage for the matrix-load core; sits between the host byte interface and the core's start_in / valid_input / X_load pins.
- Buffers host bytes in a small FIFO, issues a one-cycle start_in pulse per frame, then streams exactly FRAME_LEN bytes on X_load/valid_input.
- Waits for the core's finish before accepting the next frame.

Parameters:
- DATA_W, 8, width of host bytes and X_load.
- FRAME_LEN, 8, bytes per frame (matrix X load); must be >= 1.
- FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2.
- LOAD_DELAY, 2, idle cycles between the start_in pulse and the first possible valid_input; 0 allowed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- host_valid  in  1  host byte valid.
- host_data  in  DATA_W  host byte.
- host_ready  out  1  FIFO can accept a byte.
- frame_go  in  1  host request to start a frame.
- core_finish  in  1  finish from the core.
- start_in  out  1  one-cycle start pulse to the core.
- valid_input  out  1  X_load valid this cycle.
- X_load  out  DATA_W  byte to the core.
- busy  out  1  high whenever state != IDLE.
- frames_done  out  8  completed-frame counter; wraps 255->0.

Behaviour:
Reset:
- rst low clears the FIFO (pointers and count), state=IDLE, and all counters.
- Reset values: start_in=0, valid_input=0, X_load=0, busy=0, frames_done=0; host_ready=1 one cycle after rst deasserts.
- Reset mid-frame aborts immediately; no partial completion.

FIFO:
- Push when host_valid && host_ready.
- host_ready = !full. It is based on full only, so a concurrent pop does not let a full FIFO accept a byte.
- Pop only in STREAM when not empty.
- A byte pushed at cycle t can be popped at t+1 at the earliest; there is no fall-through.
- Pointers wrap modulo FIFO_DEPTH.
- Push while empty and pop in the same cycle cannot happen; the pop waits.

FSM states, registered:
- IDLE: busy=0. frame_go=1 moves to START. frame_go is ignored in every other state. The FIFO may fill while IDLE.
- START: start_in=1 for exactly this cycle. Next state is WAIT with delay counter = LOAD_DELAY, or STREAM if LOAD_DELAY=0.
- WAIT: decrement the counter each cycle; move to STREAM when it reaches 1.
- STREAM:
  - Each cycle with FIFO not empty: pop; the next cycle drives valid_input=1 and X_load=popped byte; byte_cnt++.
  - With FIFO empty: valid_input=0 next cycle and X_load holds its last value. Gaps are legal.
  - The pop that makes byte_cnt == FRAME_LEN moves to FINWAIT. The final valid_input beat appears in the first FINWAIT cycle.
- FINWAIT:
  - No pops.
  - core_finish=1 moves to IDLE, increments frames_done, and clears byte_cnt.
  - core_finish=1 while the final beat is being driven is still accepted.

Outputs and widths:
- valid_input and X_load are registered outputs.
- Exactly FRAME_LEN beats per frame; bytes beyond FRAME_LEN stay in the FIFO for the next frame.
- byte_cnt width = clog2(FRAME_LEN+1).

Other rules:
- core_finish outside FINWAIT is ignored.
- start_in never asserts twice without an intervening FINWAIT->IDLE.

Test Plan:
- Reset, then push 0x11,0x22,0x33,0x44 with frame_go held low, FRAME_LEN=4. Required: host_ready=1,1,1,1, then 0 with FIFO full. No start_in and no valid_input.
- From that full FIFO, pulse frame_go. Required:
  - start_in high for exactly 1 cycle.
  - After LOAD_DELAY=2 cycles, valid_input high for 4 consecutive cycles with X_load=0x11,0x22,0x33,0x44.
  - busy=1 until core_finish; frames_done 0->1 one cycle after core_finish.
- Starved stream: frame_go with an empty FIFO, then the host supplies bytes every 3rd cycle. Required: valid_input pulses isolated, 4 beats total, and X_load holds its value during the gaps.
- Back-to-back frames: 8 bytes queued, frame_go at every IDLE. Required: frame 1 carries bytes 1-4, frame 2 carries bytes 5-8; no valid_input while in FINWAIT; frames_done=2.
- Reset mid-STREAM after 2 beats. Required: all outputs 0 immediately, FIFO empty, frames_done=0, host_ready=1 after release. A new frame then starts cleanly.
- Spurious core_finish in IDLE and in STREAM. Required: no state change and frames_done unchanged. frame_go pulsed during STREAM is ignored.
